// File: rtl/spi_ctrl_multi_if.sv
// Host-side and pin-side signal bundle for spi_ctrl_multi.
// The slave modport is the controller; the master modport is the host plus the attached device.
interface spi_ctrl_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 4,
  parameter int NUM_CS     = 1
);
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  spi_miso;
  logic [NUM_CS-1:0]     spi_select;
  logic                  spi_clk_out;
  logic                  spi_mosi;
  logic                  spi_dc;
  logic                  dc_in;
  logic                  end_txn;
  logic [CSW-1:0]        cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic                  lsb_first;
  logic [DIV_WIDTH-1:0]  divider;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  start;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;

  modport slave (
    input  spi_miso, dc_in, end_txn, cs_sel, cpol, cpha, lsb_first, divider, data_in, start,
    output spi_select, spi_clk_out, spi_mosi, spi_dc, data_out, busy, done
  );

  modport master (
    output spi_miso, dc_in, end_txn, cs_sel, cpol, cpha, lsb_first, divider, data_in, start,
    input  spi_select, spi_clk_out, spi_mosi, spi_dc, data_out, busy, done
  );
endinterface

// File: rtl/spi_ctrl_multi.sv
// SPI controller with configurable word width, SCK divider, CPOL/CPHA, bit order and chip selects.
// Completion raises a one-cycle done pulse; data_out only updates on that cycle.
module spi_ctrl_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 4,
  parameter int NUM_CS     = 1
) (
  input  logic           clk,
  input  logic           rstn,
  spi_ctrl_multi_if.slave bus
);
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_data_out;
  logic [NUM_CS-1:0]     r_sel;
  logic                  r_done, r_sck, r_dc, r_end, r_cpha, r_lsb;
  logic [DIV_WIDTH-1:0]  r_div, r_div_cnt;
  logic [EW-1:0]         r_edge_cnt;

  logic                  w_accept, w_edge, w_last, w_sample, w_shift;
  logic [EW-1:0]         w_k;
  logic [NUM_CS-1:0]     w_sel_dec;
  logic [DATA_WIDTH-1:0] w_rx_nxt, w_tx_sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // An SCK edge falls on every cycle the half-period down-counter sits at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_edge      = 1'b0;
    w_last      = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    w_k         = r_edge_cnt + EW'(1);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (r_div_cnt == '0) begin
          w_edge = 1'b1;
          w_last = (w_k == LAST_EDGE);
          if (r_cpha) begin
            w_sample = ~w_k[0];
            w_shift  = w_k[0] && (w_k != EW'(1));
          end else begin
            w_sample = w_k[0];
            w_shift  = ~w_k[0] && !w_last;
          end
          if (w_last) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Out-of-range cs_sel leaves every select high.
  always_comb begin
    w_sel_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(bus.cs_sel) == i) w_sel_dec[i] = 1'b0;
    end
  end

  assign w_rx_nxt = r_lsb ? {bus.spi_miso, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], bus.spi_miso};
  assign w_tx_sh  = r_lsb ? {1'b0, r_tx[DATA_WIDTH-1:1]} : {r_tx[DATA_WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_sel      <= '1;
      r_done     <= 1'b0;
      r_sck      <= 1'b1;
      r_dc       <= 1'b0;
      r_end      <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_div      <= '0;
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_tx       <= bus.data_in;
        r_dc       <= bus.dc_in;
        r_end      <= bus.end_txn;
        r_cpha     <= bus.cpha;
        r_lsb      <= bus.lsb_first;
        r_div      <= bus.divider;
        r_div_cnt  <= bus.divider;
        r_sel      <= w_sel_dec;
        r_sck      <= bus.cpol;
        r_edge_cnt <= '0;
      end else if (r_state == S_XFER) begin
        if (w_edge) begin
          r_div_cnt  <= r_div;
          r_sck      <= ~r_sck;
          r_edge_cnt <= w_k;
          if (w_sample) r_rx <= w_rx_nxt;
          if (w_shift)  r_tx <= w_tx_sh;
          if (w_last) begin
            r_done     <= 1'b1;
            r_data_out <= w_sample ? w_rx_nxt : r_rx;
            if (r_end) r_sel <= '1;
          end
        end else begin
          r_div_cnt <= r_div_cnt - DIV_WIDTH'(1);
        end
      end
    end
  end

  assign bus.spi_select  = r_sel;
  assign bus.spi_clk_out = r_sck;
  assign bus.spi_mosi    = r_lsb ? r_tx[0] : r_tx[DATA_WIDTH-1];
  assign bus.spi_dc      = r_dc;
  assign bus.data_out    = r_data_out;
  assign bus.busy        = (r_state == S_XFER);
  assign bus.done        = r_done;
endmodule

// File: tb/tb_spi_ctrl_multi.sv
// Directed bench for spi_ctrl_multi: an 8-bit/4-select instance and a 16-bit instance.
module tb_spi_ctrl_multi;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  spi_ctrl_multi_if #(.DATA_WIDTH(8),  .DIV_WIDTH(4), .NUM_CS(4)) bus_a();
  spi_ctrl_multi_if #(.DATA_WIDTH(16), .DIV_WIDTH(4), .NUM_CS(1)) bus_b();

  spi_ctrl_multi #(.DATA_WIDTH(8),  .DIV_WIDTH(4), .NUM_CS(4)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  spi_ctrl_multi #(.DATA_WIDTH(16), .DIV_WIDTH(4), .NUM_CS(1)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  int checks = 0;
  int failures = 0;

  // Device model for bus_a: loopback, or shifts out slave_word MSB-first on each rising SCK.
  logic       loop_a = 1'b1;
  logic [7:0] slave_word = 8'h00;
  logic       slave_clr = 1'b0;
  logic       prev_sck_a = 1'b1;
  int         slave_idx = 0;

  always @(posedge clk) begin
    prev_sck_a <= slave_clr ? bus_a.cpol : bus_a.spi_clk_out;
    if (slave_clr) slave_idx <= 0;
    else if (bus_a.spi_clk_out && !prev_sck_a) slave_idx <= slave_idx + 1;
  end

  assign bus_a.spi_miso = loop_a ? bus_a.spi_mosi :
                          ((slave_idx < 8) ? slave_word[3'(7 - slave_idx)] : 1'b0);
  assign bus_b.spi_miso = bus_b.spi_mosi;

  int         t_busy, t_edges, t_mosi_bad, t_mosi_ones, t_sel_changes, t_dout_changes;
  logic [3:0] t_sel_s0, t_sel_end;
  logic       t_sck_s0, t_sck_end, t_dc_s0, t_done_end, t_done_after;
  logic [7:0] t_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup_a(input logic [7:0] d, input logic [1:0] cs, input logic endt,
                         input logic cp, input logic ch, input logic lsb, input logic [3:0] div,
                         input logic dc, input logic loop, input logic [7:0] sw);
    @(negedge clk);
    bus_a.data_in   = d;
    bus_a.cs_sel    = cs;
    bus_a.end_txn   = endt;
    bus_a.cpol      = cp;
    bus_a.cpha      = ch;
    bus_a.lsb_first = lsb;
    bus_a.divider   = div;
    bus_a.dc_in     = dc;
    loop_a          = loop;
    slave_word      = sw;
    slave_clr       = 1'b1;
    bus_a.start     = 1'b1;
  endtask

  // Accept edge, then one sample per negedge until busy drops (bounded).
  task automatic run_a(input int poke_at);
    logic       p_sck, p_mosi;
    logic [7:0] p_dout;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    slave_clr   = 1'b0;
    t_sel_s0 = bus_a.spi_select;
    t_sck_s0 = bus_a.spi_clk_out;
    t_dc_s0  = bus_a.spi_dc;
    p_sck  = bus_a.spi_clk_out;
    p_mosi = bus_a.spi_mosi;
    p_dout = bus_a.data_out;
    t_busy = bus_a.busy ? 1 : 0;
    t_mosi_ones = bus_a.spi_mosi ? 1 : 0;
    t_edges = 0; t_mosi_bad = 0; t_sel_changes = 0; t_dout_changes = 0;
    for (int it = 1; it < 400; it++) begin
      if (it == poke_at) begin
        bus_a.start   = 1'b1;
        bus_a.data_in = 8'hFF;
        bus_a.cs_sel  = 2'd0;
      end else begin
        bus_a.start = 1'b0;
      end
      @(negedge clk);
      if (bus_a.spi_clk_out !== p_sck) t_edges++;
      if (bus_a.spi_mosi !== p_mosi && !(p_sck && !bus_a.spi_clk_out)) t_mosi_bad++;
      if (!bus_a.busy) break;
      t_busy++;
      if (bus_a.spi_mosi) t_mosi_ones++;
      if (bus_a.spi_select !== t_sel_s0) t_sel_changes++;
      if (bus_a.data_out !== p_dout) t_dout_changes++;
      p_sck  = bus_a.spi_clk_out;
      p_mosi = bus_a.spi_mosi;
      p_dout = bus_a.data_out;
    end
    bus_a.start = 1'b0;
    t_done_end = bus_a.done;
    t_sel_end  = bus_a.spi_select;
    t_sck_end  = bus_a.spi_clk_out;
    t_dout     = bus_a.data_out;
    @(negedge clk);
    t_done_after = bus_a.done;
  endtask

  initial begin
    int n_b;
    int seen_done;
    rstn = 1'b0;
    bus_a.start = 0; bus_a.data_in = 0; bus_a.cs_sel = 0; bus_a.end_txn = 0; bus_a.cpol = 0;
    bus_a.cpha = 0; bus_a.lsb_first = 0; bus_a.divider = 0; bus_a.dc_in = 0;
    bus_b.start = 0; bus_b.data_in = 0; bus_b.cs_sel = 0; bus_b.end_txn = 1; bus_b.cpol = 0;
    bus_b.cpha = 0; bus_b.lsb_first = 0; bus_b.divider = 0; bus_b.dc_in = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_sel", bus_a.spi_select, 4'hF);
    check("rst_sck", bus_a.spi_clk_out, 1);
    check("rst_mosi", bus_a.spi_mosi, 0);
    check("rst_dc", bus_a.spi_dc, 0);
    check("rst_dout", bus_a.data_out, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: mode 0, divider 0, MSB-first loopback
    setup_a(8'hA5, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'h00);
    run_a(0);
    check("t1_busy", t_busy, 16);
    check("t1_edges", t_edges, 16);
    check("t1_done", t_done_end, 1);
    check("t1_done_once", t_done_after, 0);
    check("t1_dout", t_dout, 8'hA5);
    check("t1_cs_low", t_sel_s0, 4'b1110);
    check("t1_cs_steady", t_sel_changes, 0);
    check("t1_cs_end", t_sel_end, 4'hF);
    check("t1_sck_end", t_sck_end, 0);
    check("t1_dc", t_dc_s0, 1);

    // 2: mode 3, divider 2, device returns 0xC3
    setup_a(8'h3C, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 8'hC3);
    run_a(0);
    check("t2_sck_idle", t_sck_s0, 1);
    check("t2_busy", t_busy, 48);
    check("t2_edges", t_edges, 16);
    check("t2_dout", t_dout, 8'hC3);
    check("t2_mosi_on_fall", t_mosi_bad, 0);
    check("t2_sck_end", t_sck_end, 1);

    // 3: LSB-first, device feeds 1 then seven 0s
    setup_a(8'h01, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 8'h80);
    run_a(0);
    check("t3_mosi_ones", t_mosi_ones, 2);
    check("t3_dout", t_dout, 8'h01);

    // 4: hold cs2, then switch to cs1 with new mode; a start mid-transfer is ignored
    setup_a(8'h5A, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    run_a(5);
    check("t4a_busy", t_busy, 16);
    check("t4a_dout", t_dout, 8'h5A);
    check("t4a_dout_steady", t_dout_changes, 0);
    check("t4a_cs_low", t_sel_s0, 4'b1011);
    check("t4a_cs_held", t_sel_end, 4'b1011);
    check("t4a_dc", t_dc_s0, 0);
    check("t4_idle_cs", bus_a.spi_select, 4'b1011);
    setup_a(8'h96, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 8'h00);
    run_a(0);
    check("t4b_cs_swap", t_sel_s0, 4'b1101);
    check("t4b_sck_cpol", t_sck_s0, 1);
    check("t4b_busy", t_busy, 32);
    check("t4b_dout", t_dout, 8'h96);
    check("t4b_cs_end", t_sel_end, 4'hF);

    // 5: reset just before edge 5
    setup_a(8'h77, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    slave_clr   = 1'b0;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("t5_busy", bus_a.busy, 0);
    check("t5_done", bus_a.done, 0);
    check("t5_sck", bus_a.spi_clk_out, 1);
    check("t5_sel", bus_a.spi_select, 4'hF);
    check("t5_dout", bus_a.data_out, 0);
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_a.done) seen_done++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.done) seen_done++;
    end
    check("t5_no_done", seen_done, 0);
    setup_a(8'hC6, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    run_a(0);
    check("t5_after_busy", t_busy, 16);
    check("t5_after_dout", t_dout, 8'hC6);
    check("t5_after_cs", t_sel_s0, 4'b0111);

    // 6: 16-bit instance, divider 1, loopback
    @(negedge clk);
    bus_b.data_in = 16'hBEEF;
    bus_b.divider = 4'd1;
    bus_b.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0;
    n_b = bus_b.busy ? 1 : 0;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if (!bus_b.busy) break;
      n_b++;
    end
    check("t6_busy", n_b, 64);
    check("t6_done", bus_b.done, 1);
    check("t6_dout", bus_b.data_out, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_ctrl_multi.md
Name: spi_ctrl_multi

Overview:
Parametrised next-generation SPI controller for the tinyQV peripheral set. It generalises the byte-wide, fixed-rate, single-select SPI controller in four ways:
- configurable word width
- programmable SCK divider
- runtime CPOL/CPHA mode and bit order
- NUM_CS chip selects

It keeps the DC line for SPI LCDs and the start/busy handshake, and adds a one-cycle done pulse for interrupt/DMA use.

Parameters:
DATA_WIDTH, 8, bits per transfer (legal range 4..32)
DIV_WIDTH, 4, width of the SCK half-period divider input
NUM_CS, 1, number of active-low chip-select outputs (1..8); CSW = (NUM_CS>1) ? $clog2(NUM_CS) : 1

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
spi_miso  in  1  serial data from device
spi_select  out  NUM_CS  active-low chip selects
spi_clk_out  out  1  SCK
spi_mosi  out  1  serial data to device
spi_dc  out  1  data/command line
dc_in  in  1  latched to spi_dc at start accept
end_txn  in  1  1 = release CS at end of this word
cs_sel  in  CSW  index of the chip select to assert
cpol  in  1  SCK idle level, latched at accept
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept
lsb_first  in  1  bit order, latched at accept
divider  in  DIV_WIDTH  SCK half-period = divider+1 clk cycles, latched at accept
data_in  in  DATA_WIDTH  word to transmit
start  in  1  request; accepted only when busy=0
data_out  out  DATA_WIDTH  received word; valid and stable while busy=0
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a word completes

Behaviour:
- Reset (async, rstn=0) forces:
  - busy=0, done=0
  - spi_select all 1, spi_clk_out=1, spi_dc=0
  - tx/rx shift registers 0, so spi_mosi=0 and data_out=0
  - latched cpol=1
- Reset mid-transfer aborts immediately; no done pulse is produced.
- Accept (cycle A; busy=0 and start=1):
  - latch data_in into tx, plus dc_in, end_txn, cs_sel, cpol, cpha, lsb_first and divider
  - busy←1
  - spi_select[cs_sel]←0; all other selects ←1
  - spi_clk_out←cpol
  - edge counter←0, divide counter←divider
- start while busy=1 is ignored.
- Out-of-range cs_sel (≥NUM_CS): the transfer runs normally with all selects high.
- spi_mosi = tx[DATA_WIDTH-1] when MSB-first, tx[0] when LSB-first. The first bit is therefore valid from cycle A+1.
- SCK edge timing:
  - edges occur at cycles A+k·(divider+1) for k=1..2·DATA_WIDTH
  - each edge toggles spi_clk_out
  - odd k = leading edge, even k = trailing edge
- CPHA=0:
  - sample miso into rx on odd edges
  - shift tx on even edges k=2..2·DATA_WIDTH-2
- CPHA=1:
  - shift tx on odd edges k=3..2·DATA_WIDTH-1
  - sample miso into rx on even edges
- Shift direction:
  - MSB-first: tx shifts left; rx shifts in at bit 0
  - LSB-first: tx shifts right; rx shifts in at the MSB
- Completion, on the cycle of edge k=2·DATA_WIDTH (SCK is back at cpol):
  - busy←0, done←1 for exactly one cycle
  - data_out←final rx, including a sample taken on that same edge
  - if end_txn was latched as 1, all selects ←1; otherwise the selected CS stays low
- Latency from accept to busy falling is exactly 2·DATA_WIDTH·(divider+1) cycles.
- Back-to-back: start may be asserted in the cycle busy falls (busy=0 is seen on the next edge). The next accept can therefore be the cycle after done.
- CS held low (end_txn=0) and the next accept has a different cs_sel: the old CS rises and the new CS falls on the same accept cycle.
- CS held low and the next accept has a new cpol: spi_clk_out moves to the new idle level on the accept cycle.
- spi_dc changes only on accept.
- data_out is not disturbed during a transfer; the host reads it after done.

Test Plan:
1. DATA_WIDTH=8, divider=0, mode 0, MSB-first, data_in=0xA5, miso looped to mosi:
   - 16 SCK edges, one per clk
   - busy high for exactly 16 cycles; done pulses once
   - data_out=0xA5; cs0 low during the transfer and high after
2. Mode 3 (cpol=1, cpha=1), divider=2, data_in=0x3C, miso tied to a model returning 0xC3:
   - SCK idles 1, edges every 3 cycles
   - busy lasts 48 cycles; data_out=0xC3
   - mosi changes only on falling (leading) edges
3. lsb_first=1, data_in=0x01, mode 0:
   - mosi=1 before the first rising edge, then 0 for the remaining 7 bits
   - with miso fed 1,0,0,0,0,0,0,0, data_out=0x01
4. NUM_CS=4:
   - word 1: cs_sel=2, end_txn=0 → cs2 stays low after done
   - word 2: cs_sel=1, end_txn=1 → at accept cs2 rises and cs1 falls; all selects high after done
   - start pulsed mid-transfer is ignored, with no change to timing
5. rstn pulsed low at edge 5 of a transfer:
   - busy, done, spi_clk_out and selects immediately return to reset values
   - no done pulse
   - a new start after release completes normally
6. DATA_WIDTH=16 instance, divider=1, data_in=0xBEEF, loopback → busy lasts 64 cycles; data_out=0xBEEF.
